// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared datapath width, result-source encoding and ID/EX bundles
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef struct packed {
        logic [3:0] alucontrol;
        logic       regwrite;
        logic       alusrc;
        logic       branch;
        logic       memwrite1;
        logic       memwrite2;
        logic [1:0] wdsel;
        logic       jump;
        logic       jumpsel;
        logic [1:0] resultsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Everything the EX register holds; an all-zero value is a bubble.
    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            valid;
    } ex_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard check between EX and decode
module hazard_detect
    import rv_pkg::*;
(
    input  logic       valid_e,
    input  logic [1:0] resultsrc_e,
    input  logic [4:0] rd_e,
    input  logic       valid_d,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    output logic       load_use
);

    // x0 is never a real destination, so a load to it cannot create a dependency.
    assign load_use = valid_e && (resultsrc_e == RESULTSRC_LOAD) && (rd_e != 5'd0) &&
                      valid_d && ((rd_e == rs1_d) || (rd_e == rs2_d));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flush, hold and load-use bubble insertion
module id_ex_stage
    import rv_pkg::*;
#(
    // Reset value of bubble_cnt; 0 in normal use.
    parameter logic [31:0] CNT_RESET = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      alucontrol_d,
    input  logic            regwrite_d,
    input  logic            alusrc_d,
    input  logic            branch_d,
    input  logic            memwrite1_d,
    input  logic            memwrite2_d,
    input  logic [1:0]      wdsel_d,
    input  logic            jump_d,
    input  logic            jumpsel_d,
    input  logic [1:0]      resultsrc_d,
    input  logic [1:0]      aluop_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pcplus4_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] immext_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [2:0]      funct3_d,
    input  logic            valid_d,
    input  logic            flush_e,
    input  logic            hold,
    output logic [3:0]      alucontrol_e,
    output logic            regwrite_e,
    output logic            alusrc_e,
    output logic            branch_e,
    output logic            memwrite1_e,
    output logic            memwrite2_e,
    output logic [1:0]      wdsel_e,
    output logic            jump_e,
    output logic            jumpsel_e,
    output logic [1:0]      resultsrc_e,
    output logic [1:0]      aluop_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pcplus4_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] immext_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [2:0]      funct3_e,
    output logic            valid_e,
    output logic            stall_d,
    output logic [31:0]     bubble_cnt
);

    ex_t  d_bundle;
    ex_t  ex_q;
    logic load_use;

    always_comb begin
        d_bundle                = '0;
        d_bundle.ctrl.alucontrol = alucontrol_d;
        d_bundle.ctrl.regwrite  = regwrite_d;
        d_bundle.ctrl.alusrc    = alusrc_d;
        d_bundle.ctrl.branch    = branch_d;
        d_bundle.ctrl.memwrite1 = memwrite1_d;
        d_bundle.ctrl.memwrite2 = memwrite2_d;
        d_bundle.ctrl.wdsel     = wdsel_d;
        d_bundle.ctrl.jump      = jump_d;
        d_bundle.ctrl.jumpsel   = jumpsel_d;
        d_bundle.ctrl.resultsrc = resultsrc_d;
        d_bundle.ctrl.aluop     = aluop_d;
        d_bundle.pc             = pc_d;
        d_bundle.pcplus4        = pcplus4_d;
        d_bundle.rd1            = rd1_d;
        d_bundle.rd2            = rd2_d;
        d_bundle.immext         = immext_d;
        d_bundle.rs1            = rs1_d;
        d_bundle.rs2            = rs2_d;
        d_bundle.rd             = rd_d;
        d_bundle.funct3         = funct3_d;
        d_bundle.valid          = valid_d;
    end

    hazard_detect u_hazard_detect (
        .valid_e     (ex_q.valid),
        .resultsrc_e (ex_q.ctrl.resultsrc),
        .rd_e        (ex_q.rd),
        .valid_d     (valid_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .load_use    (load_use)
    );

    // A flush discards whatever is in decode, so there is nothing left to stall for.
    assign stall_d = ~flush_e & (hold | load_use);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q       <= '0;
            bubble_cnt <= CNT_RESET;
        end else if (flush_e) begin
            ex_q <= '0;
        end else if (hold) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
            if (bubble_cnt != 32'hFFFF_FFFF) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end else begin
            ex_q <= d_bundle;
        end
    end

    assign alucontrol_e = ex_q.ctrl.alucontrol;
    assign regwrite_e   = ex_q.ctrl.regwrite;
    assign alusrc_e     = ex_q.ctrl.alusrc;
    assign branch_e     = ex_q.ctrl.branch;
    assign memwrite1_e  = ex_q.ctrl.memwrite1;
    assign memwrite2_e  = ex_q.ctrl.memwrite2;
    assign wdsel_e      = ex_q.ctrl.wdsel;
    assign jump_e       = ex_q.ctrl.jump;
    assign jumpsel_e    = ex_q.ctrl.jumpsel;
    assign resultsrc_e  = ex_q.ctrl.resultsrc;
    assign aluop_e      = ex_q.ctrl.aluop;
    assign pc_e         = ex_q.pc;
    assign pcplus4_e    = ex_q.pcplus4;
    assign rd1_e        = ex_q.rd1;
    assign rd2_e        = ex_q.rd2;
    assign immext_e     = ex_q.immext;
    assign rs1_e        = ex_q.rs1;
    assign rs2_e        = ex_q.rs2;
    assign rd_e         = ex_q.rd;
    assign funct3_e     = ex_q.funct3;
    assign valid_e      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk, reset, flush_e, hold;
    logic [3:0]  alucontrol_d;
    logic        regwrite_d, alusrc_d, branch_d, memwrite1_d, memwrite2_d, jump_d, jumpsel_d, valid_d;
    logic [1:0]  wdsel_d, resultsrc_d, aluop_d;
    logic [31:0] pc_d, pcplus4_d, rd1_d, rd2_d, immext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [2:0]  funct3_d;

    logic [3:0]  alucontrol_e, s_alucontrol_e;
    logic        regwrite_e, alusrc_e, branch_e, memwrite1_e, memwrite2_e, jump_e, jumpsel_e, valid_e, stall_d;
    logic        s_regwrite_e, s_alusrc_e, s_branch_e, s_memwrite1_e, s_memwrite2_e, s_jump_e, s_jumpsel_e, s_valid_e, s_stall_d;
    logic [1:0]  wdsel_e, resultsrc_e, aluop_e, s_wdsel_e, s_resultsrc_e, s_aluop_e;
    logic [31:0] pc_e, pcplus4_e, rd1_e, rd2_e, immext_e, bubble_cnt;
    logic [31:0] s_pc_e, s_pcplus4_e, s_rd1_e, s_rd2_e, s_immext_e, s_bubble_cnt;
    logic [4:0]  rs1_e, rs2_e, rd_e, s_rs1_e, s_rs2_e, s_rd_e;
    logic [2:0]  funct3_e, s_funct3_e;

    logic [195:0] d_vec, e_vec, s_e_vec;
    assign d_vec = {alucontrol_d, regwrite_d, alusrc_d, branch_d, memwrite1_d, memwrite2_d, wdsel_d, jump_d, jumpsel_d,
                    resultsrc_d, aluop_d, pc_d, pcplus4_d, rd1_d, rd2_d, immext_d, rs1_d, rs2_d, rd_d, funct3_d, valid_d};
    assign e_vec = {alucontrol_e, regwrite_e, alusrc_e, branch_e, memwrite1_e, memwrite2_e, wdsel_e, jump_e, jumpsel_e,
                    resultsrc_e, aluop_e, pc_e, pcplus4_e, rd1_e, rd2_e, immext_e, rs1_e, rs2_e, rd_e, funct3_e, valid_e};
    assign s_e_vec = {s_alucontrol_e, s_regwrite_e, s_alusrc_e, s_branch_e, s_memwrite1_e, s_memwrite2_e, s_wdsel_e, s_jump_e,
                      s_jumpsel_e, s_resultsrc_e, s_aluop_e, s_pc_e, s_pcplus4_e, s_rd1_e, s_rd2_e, s_immext_e, s_rs1_e,
                      s_rs2_e, s_rd_e, s_funct3_e, s_valid_e};

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .alucontrol_d(alucontrol_d), .regwrite_d(regwrite_d), .alusrc_d(alusrc_d), .branch_d(branch_d),
        .memwrite1_d(memwrite1_d), .memwrite2_d(memwrite2_d), .wdsel_d(wdsel_d), .jump_d(jump_d),
        .jumpsel_d(jumpsel_d), .resultsrc_d(resultsrc_d), .aluop_d(aluop_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .funct3_d(funct3_d), .valid_d(valid_d),
        .flush_e(flush_e), .hold(hold),
        .alucontrol_e(alucontrol_e), .regwrite_e(regwrite_e), .alusrc_e(alusrc_e), .branch_e(branch_e),
        .memwrite1_e(memwrite1_e), .memwrite2_e(memwrite2_e), .wdsel_e(wdsel_e), .jump_e(jump_e),
        .jumpsel_e(jumpsel_e), .resultsrc_e(resultsrc_e), .aluop_e(aluop_e),
        .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .funct3_e(funct3_e), .valid_e(valid_e),
        .stall_d(stall_d), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_RESET(32'hFFFF_FFFE)) dut_sat (
        .clk(clk), .reset(reset),
        .alucontrol_d(alucontrol_d), .regwrite_d(regwrite_d), .alusrc_d(alusrc_d), .branch_d(branch_d),
        .memwrite1_d(memwrite1_d), .memwrite2_d(memwrite2_d), .wdsel_d(wdsel_d), .jump_d(jump_d),
        .jumpsel_d(jumpsel_d), .resultsrc_d(resultsrc_d), .aluop_d(aluop_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .funct3_d(funct3_d), .valid_d(valid_d),
        .flush_e(flush_e), .hold(hold),
        .alucontrol_e(s_alucontrol_e), .regwrite_e(s_regwrite_e), .alusrc_e(s_alusrc_e), .branch_e(s_branch_e),
        .memwrite1_e(s_memwrite1_e), .memwrite2_e(s_memwrite2_e), .wdsel_e(s_wdsel_e), .jump_e(s_jump_e),
        .jumpsel_e(s_jumpsel_e), .resultsrc_e(s_resultsrc_e), .aluop_e(s_aluop_e),
        .pc_e(s_pc_e), .pcplus4_e(s_pcplus4_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .immext_e(s_immext_e),
        .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e), .funct3_e(s_funct3_e), .valid_e(s_valid_e),
        .stall_d(s_stall_d), .bubble_cnt(s_bubble_cnt)
    );

    typedef struct packed {
        logic [195:0] v;
        logic         valid;
        logic [4:0]   rd;
        logic [1:0]   res;
    } exp_t;

    exp_t        sb[$];
    exp_t        m;
    logic [31:0] m_cnt, m_scnt, base, keep;
    logic        obs_stall;
    int          total = 0;
    int          bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [195:0] v);
        {alucontrol_d, regwrite_d, alusrc_d, branch_d, memwrite1_d, memwrite2_d, wdsel_d, jump_d, jumpsel_d,
         resultsrc_d, aluop_d, pc_d, pcplus4_d, rd1_d, rd2_d, immext_d, rs1_d, rs2_d, rd_d, funct3_d, valid_d} = v;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic [1:0] res, input logic h, input logic f);
        logic [223:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        set_vec(r[195:0]);
        valid_d = v; rs1_d = s1; rs2_d = s2; rd_d = d; resultsrc_d = res;
        hold = h; flush_e = f;
    endtask

    // Called just after a falling edge with inputs driven; returns #1 after the next rising edge.
    task automatic step(input string tag);
        exp_t nxt;
        logic haz, est;
        #1;
        haz = m.valid && (m.res == 2'b01) && (m.rd != 5'd0) && valid_d && ((m.rd == rs1_d) || (m.rd == rs2_d));
        est = !flush_e && (hold || haz);
        obs_stall = stall_d;
        check({tag, ".stall"}, 200'(stall_d), 200'(est));
        if (flush_e) nxt = '0;
        else if (hold) nxt = m;
        else if (haz) begin
            nxt = '0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
        end else begin
            nxt.v = d_vec; nxt.valid = valid_d; nxt.rd = rd_d; nxt.res = resultsrc_d;
        end
        sb.push_back(nxt);
        @(posedge clk);
        #1;
        m = sb.pop_front();
        check({tag, ".e"}, 200'(e_vec), 200'(m.v));
        check({tag, ".sat_e"}, 200'(s_e_vec), 200'(m.v));
        check({tag, ".cnt"}, 200'(bubble_cnt), 200'(m_cnt));
        check({tag, ".sat_cnt"}, 200'(s_bubble_cnt), 200'(m_scnt));
    endtask

    task automatic model_reset();
        m = '0; m_cnt = 32'd0; m_scnt = 32'hFFFF_FFFE;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush_e = 1'b0;
        set_vec('0);
        model_reset();
        #2;
        check("rst.e", 200'(e_vec), 200'd0);
        check("rst.cnt", 200'(bubble_cnt), 200'd0);
        check("rst.sat_cnt", 200'(s_bubble_cnt), 200'(32'hFFFF_FFFE));
        check("rst.stall", 200'(stall_d), 200'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            step("rnd");
        end

        // load then dependent use
        @(negedge clk); drive(0, 0, 0, 0, 2'b00, 0, 0); step("lu.pre");
        @(negedge clk); drive(1, 1, 2, 5, 2'b01, 0, 0); step("lu.lw");
        base = m_cnt;
        @(negedge clk); drive(1, 5, 6, 8, 2'b00, 0, 0); step("lu.use");
        check("lu.stall1", 200'(obs_stall), 200'd1);
        check("lu.valid0", 200'(valid_e), 200'd0);
        check("lu.cnt1", 200'(bubble_cnt), 200'(base + 32'd1));
        step("lu.again");
        check("lu.stall_gone", 200'(obs_stall), 200'd0);
        check("lu.valid1", 200'(valid_e), 200'd1);

        // load to x0 never stalls
        @(negedge clk); drive(0, 0, 0, 0, 2'b00, 0, 0); step("x0.pre");
        @(negedge clk); drive(1, 3, 3, 0, 2'b01, 0, 0); step("x0.lw");
        base = m_cnt;
        @(negedge clk); drive(1, 4, 0, 9, 2'b00, 0, 0); step("x0.use");
        check("x0.stall", 200'(obs_stall), 200'd0);
        check("x0.valid", 200'(valid_e), 200'd1);
        check("x0.cnt", 200'(bubble_cnt), 200'(base));

        // hold for three cycles
        @(negedge clk); drive(1, 1, 2, 3, 2'b00, 0, 0); keep = rd1_d; step("hold.ld");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 1, 2, 4, 2'b00, 1, 0); step("hold.on");
            check("hold.rd1", 200'(rd1_e), 200'(keep));
            check("hold.stall", 200'(obs_stall), 200'd1);
        end
        @(negedge clk); drive(1, 1, 2, 4, 2'b00, 0, 0); keep = rd1_d; step("hold.off");
        check("hold.rd1_new", 200'(rd1_e), 200'(keep));

        // flush beats hold and a load-use hazard
        @(negedge clk); drive(0, 0, 0, 0, 2'b00, 0, 0); step("fl.pre");
        @(negedge clk); drive(1, 1, 2, 7, 2'b01, 0, 0); regwrite_d = 1'b1; step("fl.lw");
        base = m_cnt;
        @(negedge clk); drive(1, 7, 0, 9, 2'b00, 1, 1); regwrite_d = 1'b1; step("fl.flush");
        check("fl.stall", 200'(obs_stall), 200'd0);
        check("fl.valid", 200'(valid_e), 200'd0);
        check("fl.regwrite", 200'(regwrite_e), 200'd0);
        check("fl.cnt", 200'(bubble_cnt), 200'(base));

        // asynchronous reset in the middle of a hold
        @(negedge clk); drive(1, 1, 2, 3, 2'b00, 0, 0); step("ar.ld");
        check("ar.valid1", 200'(valid_e), 200'd1);
        @(negedge clk); drive(1, 1, 2, 3, 2'b00, 1, 0);
        #2 reset = 1'b1;
        #1;
        check("ar.e", 200'(e_vec), 200'd0);
        check("ar.sat_e", 200'(s_e_vec), 200'd0);
        check("ar.cnt", 200'(bubble_cnt), 200'd0);
        check("ar.sat_cnt", 200'(s_bubble_cnt), 200'(32'hFFFF_FFFE));
        check("ar.stall_hold", 200'(stall_d), 200'd1);
        hold = 1'b0;
        #1;
        check("ar.stall", 200'(stall_d), 200'd0);
        @(posedge clk);
        #1;
        check("ar.e_edge", 200'(e_vec), 200'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive(1, 1, 2, 6, 2'b00, 0, 0); step("ar.first");
        check("ar.first_valid", 200'(valid_e), 200'd1);

        // saturation from 0xFFFF_FFFE with three hazards
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 1, 2, 5, 2'b01, 0, 0); step("sat.lw");
            @(negedge clk); drive(1, 0, 5, 8, 2'b00, 0, 0); step("sat.use");
            check("sat.valid", 200'(valid_e), 200'd0);
        end
        check("sat.cnt_max", 200'(s_bubble_cnt), 200'(32'hFFFF_FFFF));
        check("sat.cnt_main", 200'(bubble_cnt), 200'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 XLEN, 32, datapath width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 alucontrol_d, regwrite_d, alusrc_d, branch_d, memwrite1_d, memwrite2_d, wdsel_d, jump_d, jumpsel_d, resultsrc_d, aluop_d  in  4/1/1/1/1/1/2/1/1/2/2  decode-stage control bundle.
REQ-005 pc_d, pcplus4_d, rd1_d, rd2_d, immext_d  in  XLEN each  decode-stage data.
REQ-006 rs1_d, rs2_d, rd_d  in  5 each; funct3_d  in  3; valid_d  in  1  decoded instruction is real.
REQ-007 flush_e  in  1  taken branch/jump resolved in EX; kill next EX contents.
REQ-008 hold  in  1  downstream busy, for example a multi-cycle multiply; freeze EX register.
REQ-009 All *_e outputs  out  same widths as REQ-004..006  registered EX-stage copies; valid_e  out  1.
REQ-010 stall_d  out  1  freeze PC and IF/ID register this cycle.
REQ-011 bubble_cnt  out  32  saturating count of load-use bubbles inserted.

Function
REQ-012 A load-use hazard SHALL be flagged when valid_e=1, resultsrc_e=RESULTSRC_LOAD (2'b01), rd_e!=0, valid_d=1, and rd_e equals rs1_d or rs2_d.
REQ-013 stall_d SHALL be combinational: hold OR load-use hazard; flush_e SHALL force stall_d=0.
REQ-014 Per-edge priority SHALL be reset > flush_e > hold > load-use > normal load.
REQ-015 flush_e=1: the next state SHALL be a bubble.
REQ-016 hold=1 with no flush: every EX register, including valid_e, SHALL retain its value.
REQ-017 Load-use with no hold or flush: the next state SHALL be a bubble, and bubble_cnt SHALL increment.
REQ-018 Normal: every *_e register SHALL capture its *_d counterpart, and valid_e SHALL equal valid_d.
REQ-019 A bubble SHALL set valid_e=0 and zero every control and data field; regwrite_e, memwrite1_e, memwrite2_e, branch_e and jump_e SHALL therefore be 0.
REQ-020 Latency SHALL be exactly 1 cycle from D inputs to E outputs when not held.
REQ-021 One load-use stall SHALL last exactly one cycle, because the bubble clears valid_e and releases the hazard.
REQ-022 bubble_cnt SHALL saturate at 32'hFFFF_FFFF without wrap-around, and SHALL NOT count flush-induced bubbles.
REQ-023 Hazard detection SHALL ignore rd_e=0 and SHALL ignore valid_d=0.

Reset
REQ-024 While reset=1, every output register SHALL be 0 immediately, without waiting for clk; this includes valid_e and bubble_cnt.
REQ-025 When reset asserts mid-hold or mid-stall, state SHALL clear, and the first post-reset edge SHALL perform a normal load.
REQ-026 stall_d SHALL be 0 during reset whenever hold=0.

Structure
REQ-027 The shared package rv_pkg SHALL hold XLEN, RESULTSRC_LOAD, and the ctrl_t struct that bundles the REQ-004 controls.
REQ-028 Load-use comparison SHALL live in a combinational sub-module named hazard_detect; id_ex_stage SHALL hold all sequential state.
REQ-029 The block SHALL contain no latches, and only bubble_cnt SHALL contain arithmetic.

Verification
REQ-030 The bench SHALL cover a load then a dependent use: lw x5 in EX (rd_e=5, resultsrc_e=01), then add with rs1_d=5 → stall_d=1 for one cycle, valid_e=0 next cycle, bubble_cnt=1.
REQ-031 The bench SHALL cover a load writing x0: load with rd_e=0 and rs2_d=0 → stall_d=0, and no bubble.
REQ-032 The bench SHALL cover hold=1 for 3 cycles with rd1_d changing → rd1_e stays constant, stall_d=1 throughout, and rd1_e updates on the first edge after hold drops.
REQ-033 The bench SHALL cover flush_e=1 together with hold=1 and a load-use hazard → next cycle valid_e=0 and regwrite_e=0, bubble_cnt unchanged, stall_d=0 during the flush cycle.
REQ-034 The bench SHALL cover async reset mid-cycle with valid_e=1 → all outputs 0 before the next clk edge.
REQ-035 The bench SHALL cover bubble_cnt preloaded near 32'hFFFF_FFFE followed by 3 load-use hazards → bubble_cnt holds at 32'hFFFF_FFFF.
